// File: rtl/conv_8x32_maxpool_ctrl.sv
// conv_8x32_maxpool_ctrl: streaming max-pool over WINDOW unsigned samples.
// Samples arrive on a valid/ready input; one result per window leaves on a
// valid/ready output. Define CONV_MAXPOOL_ARGMAX_EN to also report the
// position of the maximum (idx_out); without it only the maximum is kept.

// Unsigned strict less-than, shared by the accumulate path.
module conv_8x32_comp_less #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         lt_out
);
  assign lt_out = (a_in < b_in);
endmodule

module conv_8x32_maxpool_ctrl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int WINDOW     = 4,
  localparam int IDX_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] max_out,
`ifdef CONV_MAXPOOL_ARGMAX_EN
  output logic [IDX_W-1:0]      idx_out,
`endif
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Index of the last sample of a window.
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WINDOW - 1);

  state_t                state, state_nxt;
  logic                  rst_done;
  logic                  accept;
  logic                  lt;
  logic [IDX_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] max_reg;
`ifdef CONV_MAXPOOL_ARGMAX_EN
  logic [IDX_W-1:0]      idx_reg;
`endif

  assign accept  = in_valid && in_ready;
  assign max_out = max_reg;
`ifdef CONV_MAXPOOL_ARGMAX_EN
  assign idx_out = idx_reg;
`endif

  // Single comparator: does the incoming sample beat the running maximum?
  conv_8x32_comp_less #(.W(DATA_WIDTH)) u_comp (
    .a_in   (max_reg),
    .b_in   (in_data),
    .lt_out (lt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; clear wins over any handshake.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_done;
        if (in_valid && rst_done) state_nxt = (WINDOW == 1) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = rst_done;
        if (in_valid && rst_done && cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Keeps in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  // Datapath: sample counter, running maximum and (optionally) its position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      max_reg <= '0;
`ifdef CONV_MAXPOOL_ARGMAX_EN
      idx_reg <= '0;
`endif
    end else if (clear) begin
      cnt     <= '0;
      max_reg <= '0;
`ifdef CONV_MAXPOOL_ARGMAX_EN
      idx_reg <= '0;
`endif
    end else if (accept) begin
      if (state == IDLE) begin
        // First sample always seeds the maximum.
        max_reg <= in_data;
        cnt     <= (WINDOW == 1) ? '0 : IDX_W'(1);
`ifdef CONV_MAXPOOL_ARGMAX_EN
        idx_reg <= '0;
`endif
      end else begin
        // Strict compare so ties keep the earliest position.
        if (lt) begin
          max_reg <= in_data;
`ifdef CONV_MAXPOOL_ARGMAX_EN
          idx_reg <= cnt;
`endif
        end
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_8x32_maxpool_ctrl.sv
// Scoreboard bench for conv_8x32_maxpool_ctrl: a WINDOW=4 instance and a
// WINDOW=1 instance share clock and reset; expected results are queued as
// windows are issued and popped by monitors on each output handshake.
module tb_conv_8x32_maxpool_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;

  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] max_out;
  logic [1:0] idx_out;
  logic       out_valid;
  logic       out_ready = 1'b1;

  logic [7:0] in_data1 = 8'd0;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] max_out1;
  logic [0:0] idx_out1;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;

  typedef struct packed {
    logic [7:0] max;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  exp_t mon_e, mon_e1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  conv_8x32_maxpool_ctrl #(.DATA_WIDTH(8), .WINDOW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .max_out   (max_out),
`ifdef CONV_MAXPOOL_ARGMAX_EN
    .idx_out   (idx_out),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  conv_8x32_maxpool_ctrl #(.DATA_WIDTH(8), .WINDOW(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .in_data   (in_data1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .max_out   (max_out1),
`ifdef CONV_MAXPOOL_ARGMAX_EN
    .idx_out   (idx_out1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1)
  );

`ifndef CONV_MAXPOOL_ARGMAX_EN
  assign idx_out  = 2'd0;
  assign idx_out1 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the WINDOW=4 instance.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("result_without_expectation", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("max_out", {24'd0, max_out}, {24'd0, mon_e.max});
`ifdef CONV_MAXPOOL_ARGMAX_EN
        check("idx_out", {30'd0, idx_out}, {30'd0, mon_e.idx});
`endif
      end
    end
  end

  // Monitor for the WINDOW=1 instance.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        check("w1_result_without_expectation", {31'd0, out_valid1}, 32'd0);
      end else begin
        mon_e1 = q1.pop_front();
        check("w1_max_out", {24'd0, max_out1}, {24'd0, mon_e1.max});
`ifdef CONV_MAXPOOL_ARGMAX_EN
        check("w1_idx_out", {31'd0, idx_out1}, {30'd0, mon_e1.idx});
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted; returns 1 time unit after
  // the accepting edge with in_valid dropped and junk on the data bus.
  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic send1(input logic [7:0] d);
    int t;
    t = 0;
    in_data1  = d;
    in_valid1 = 1'b1;
    @(negedge clk);
    while (!in_ready1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready1) check("w1_send_timeout", {31'd0, in_ready1}, 32'd1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_data1  = 8'hEE;
  endtask

  task automatic window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [7:0] emax, input logic [1:0] eidx);
    q.push_back('{max: emax, idx: eidx});
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state while rst is held.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_max_out", {24'd0, max_out}, 32'd0);
    check("rst_idx_out", {30'd0, idx_out}, 32'd0);
    check("rst_w1_in_ready", {31'd0, in_ready1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_before_first_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Back-to-back window with one-cycle result latency.
    window(8'd3, 8'd9, 8'd2, 8'd7, 8'd9, 2'd1);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("latency_in_ready", {31'd0, in_ready}, 32'd0);
    check("latency_max", {24'd0, max_out}, 32'd9);

    // Ties keep the earliest index; maximum at the last position.
    window(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 2'd0);
    window(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 2'd3);
    idle(1);

    // Downstream back-pressure: result held stable, no input accepted.
    out_ready = 1'b0;
    window(8'd6, 8'd1, 8'd6, 8'd2, 8'd6, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_max", {24'd0, max_out}, 32'd6);
      check("stall_idx", {30'd0, idx_out}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("released_in_ready", {31'd0, in_ready}, 32'd1);
    check("released_out_valid", {31'd0, out_valid}, 32'd0);
    window(8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 2'd3);
    idle(1);

    // Input stalls with junk on the bus must not disturb the window.
    q.push_back('{max: 8'd8, idx: 2'd1});
    send(8'd4);
    idle(3);
    send(8'd8);
    idle(1);
    send(8'd6);
    idle(2);
    send(8'd1);
    idle(1);

    // Clear mid-window overrides a simultaneous valid sample.
    send(8'd10);
    send(8'd50);
    in_data  = 8'd200;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_max", {24'd0, max_out}, 32'd0);
    check("clear_idx", {30'd0, idx_out}, 32'd0);
    check("clear_out_valid", {31'd0, out_valid}, 32'd0);
    check("clear_in_ready", {31'd0, in_ready}, 32'd1);
    window(8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 2'd3);
    idle(1);

    // Asynchronous reset mid-window discards the partial result.
    send(8'd99);
    send(8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_max", {24'd0, max_out}, 32'd0);
    check("async_rst_idx", {30'd0, idx_out}, 32'd0);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'd7);
    send(8'd3);
    send(8'd12);
    check("no_stale_out_valid", {31'd0, out_valid}, 32'd0);
    q.push_back('{max: 8'd12, idx: 2'd2});
    send(8'd12);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    idle(1);

    // WINDOW=1 instance: every sample is a complete window.
    q1.push_back('{max: 8'd77, idx: 2'd0});
    send1(8'd77);
    check("w1_latency_out_valid", {31'd0, out_valid1}, 32'd1);
    check("w1_max_direct", {24'd0, max_out1}, 32'd77);
    q1.push_back('{max: 8'd200, idx: 2'd0});
    send1(8'd200);
    check("w1_second_out_valid", {31'd0, out_valid1}, 32'd1);

    idle(3);
    check("scoreboard_drained", q.size(), 32'd0);
    check("w1_scoreboard_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
